// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   CPU_WIDTH : datapath / PC width
//   INST_NOP  : instruction word presented before the first fetch (addi x0,x0,0)
//   if_state_e: fetch sequencer states
package if_fetch_ctrl_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;

  typedef enum logic [2:0] {
    IF_IDLE = 3'd0,
    IF_REQ  = 3'd1,
    IF_WAIT = 3'd2,
    IF_HOLD = 3'd3,
    IF_HALT = 3'd4
  } if_state_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// PC register and single-outstanding instruction-fetch sequencer.
// Holds curr_pc for mux_pc, fetches one instruction at a time over a
// req/gnt/rvalid handshake, and presents it to decode with valid/ready.
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   next_pc             next PC from mux_pc, latched at retire
//   curr_pc, pc_ena     PC being fetched/held, and mux_pc enable (retire cycle)
//   imem_req/addr       fetch request and address (address = curr_pc)
//   imem_gnt/rvalid     request accepted / read data valid
//   imem_rdata          instruction word from memory
//   inst_valid/inst     fetched instruction towards decode
//   inst_pc             PC of the held instruction
//   inst_ready          decode/execute retires the instruction this cycle
//   misalign_err        sticky, set when a retire supplied a misaligned next_pc
//   retire_cnt          wrapping count of retired instructions
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CPU_WIDTH-1:0] next_pc,
  output logic [CPU_WIDTH-1:0] curr_pc,
  output logic                 pc_ena,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic                 inst_valid,
  output logic [31:0]          inst,
  output logic [CPU_WIDTH-1:0] inst_pc,
  input  logic                 inst_ready,
  output logic                 misalign_err,
  output logic [CNT_WIDTH-1:0] retire_cnt
);

  if_state_e state_q, state_d;
  logic      load_inst;
  logic      retire;
  logic      next_misaligned;

  assign next_misaligned = (next_pc[1:0] != 2'b00);
  assign imem_addr       = curr_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // gnt and rvalid are only consulted in the state that expects them, which
  // is what drops stale or post-reset memory responses.
  always_comb begin
    state_d   = state_q;
    load_inst = 1'b0;
    retire    = 1'b0;
    imem_req  = 1'b0;
    pc_ena    = 1'b0;
    case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        if (imem_rvalid) begin
          load_inst = 1'b1;
          state_d   = IF_HOLD;
        end
      end
      IF_HOLD: begin
        pc_ena = inst_ready;
        if (inst_ready) begin
          retire  = 1'b1;
          state_d = next_misaligned ? IF_HALT : IF_REQ;
        end
      end
      IF_HALT: state_d = IF_HALT;
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curr_pc      <= RESET_PC;
      inst         <= INST_NOP;
      inst_pc      <= RESET_PC;
      inst_valid   <= 1'b0;
      misalign_err <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      if (load_inst) begin
        inst       <= imem_rdata;
        inst_pc    <= curr_pc;
        inst_valid <= 1'b1;
      end
      if (retire) begin
        inst_valid <= 1'b0;
        retire_cnt <= retire_cnt + CNT_WIDTH'(1);
        // A misaligned target keeps the old PC so the faulting site is visible.
        if (next_misaligned) begin
          misalign_err <= 1'b1;
        end else begin
          curr_pc <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic [31:0] curr_pc;
  logic        pc_ena;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        misalign_err;
  logic [2:0]  retire_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned exp_cnt = 0;

  if_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .CNT_WIDTH (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_pc      (next_pc),
    .curr_pc      (curr_pc),
    .pc_ena       (pc_ena),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready),
    .misalign_err (misalign_err),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge that put the controller in REQ for addr.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] nxt, input int unsigned gnt_wait,
                       input int unsigned hold_wait);
    chk("req_high", imem_req, 1);
    chk("req_addr", imem_addr, addr);
    chk("req_valid_low", inst_valid, 0);
    imem_gnt = (gnt_wait == 0);
    for (int unsigned i = 0; i < gnt_wait; i++) begin
      tick();
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, addr);
      chk("stall_valid", inst_valid, 0);
    end
    imem_gnt = 1'b1;
    tick();
    chk("wait_req_low", imem_req, 0);
    chk("wait_valid_low", inst_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    chk("hold_valid", inst_valid, 1);
    chk("hold_inst", inst, data);
    chk("hold_pc", inst_pc, addr);
    chk("hold_req_low", imem_req, 0);
    chk("hold_cnt", retire_cnt, exp_cnt);
    inst_ready = 1'b0;
    next_pc    = nxt;
    for (int unsigned i = 0; i < hold_wait; i++) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~data;
      #1;
      chk("stall_pc_ena", pc_ena, 0);
      tick();
      imem_rvalid = 1'b0;
      chk("stall_inst", inst, data);
      chk("stall_inst_pc", inst_pc, addr);
      chk("stall_inst_valid", inst_valid, 1);
    end
    inst_ready = 1'b1;
    #1;
    chk("retire_pc_ena", pc_ena, 1);
    tick();
    inst_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 8;
    chk("post_cnt", retire_cnt, exp_cnt);
    chk("post_valid", inst_valid, 0);
    chk("post_pc_ena", pc_ena, 0);
    if (nxt[1:0] == 2'b00) begin
      chk("post_curr_pc", curr_pc, nxt);
      chk("post_misalign", misalign_err, 0);
    end else begin
      chk("halt_curr_pc", curr_pc, addr);
      chk("halt_misalign", misalign_err, 1);
      chk("halt_req", imem_req, 0);
    end
  endtask

  task automatic check_reset_values;
    chk("rst_curr_pc", curr_pc, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pc_ena", pc_ena, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_cnt", retire_cnt, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    next_pc     = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    #1;
    chk("idle_req", imem_req, 0);
    tick();

    // Full-speed sequential fetches, a stalled retire with a spurious rvalid,
    // a taken branch, and enough retires to wrap the 3-bit counter.
    fetch(32'h0000_0000, 32'h1111_0001, 32'h0000_0004, 0, 0);
    fetch(32'h0000_0004, 32'h2222_0002, 32'h0000_0008, 0, 0);
    fetch(32'h0000_0008, 32'h3333_0003, 32'h0000_000C, 0, 0);
    fetch(32'h0000_000C, 32'h4444_0004, 32'h0000_0010, 0, 4);
    fetch(32'h0000_0010, 32'h5555_0005, 32'h0000_0100, 0, 0);
    fetch(32'h0000_0100, 32'h6666_0006, 32'h0000_0104, 0, 0);
    fetch(32'h0000_0104, 32'h7777_0007, 32'h0000_0108, 0, 0);
    fetch(32'h0000_0108, 32'h8888_0008, 32'h0000_010C, 0, 0);
    chk("cnt_wrapped", retire_cnt, 0);
    fetch(32'h0000_010C, 32'h9999_0009, 32'h0000_0102, 0, 0);

    // HALT ignores gnt and rvalid.
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    repeat (3) begin
      tick();
      chk("halt_req_stay", imem_req, 0);
      chk("halt_valid_stay", inst_valid, 0);
    end
    chk("halt_misalign_sticky", misalign_err, 1);
    chk("halt_pc_stay", curr_pc, 32'h0000_010C);
    chk("halt_inst_stay", inst, 32'h9999_0009);
    imem_rvalid = 1'b0;

    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_cnt = 0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle2_req", imem_req, 0);
    tick();

    fetch(32'h0000_0000, 32'hA000_0001, 32'h0000_0004, 0, 0);
    fetch(32'h0000_0004, 32'hA000_0002, 32'h0000_0008, 5, 0);

    // Reset while waiting for read data; the late response must be dropped.
    chk("pre_wait_addr", imem_addr, 32'h0000_0008);
    imem_gnt = 1'b1;
    tick();
    chk("in_wait_req", imem_req, 0);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_cnt = 0;
    imem_gnt = 1'b0;
    tick();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0BAD;
    #1;
    chk("idle3_req", imem_req, 0);
    tick();
    chk("drop_valid", inst_valid, 0);
    chk("drop_inst", inst, 32'h0000_0013);
    chk("drop_req", imem_req, 1);
    chk("drop_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b0;
    chk("drop_valid_req", inst_valid, 0);
    chk("drop_inst_req", inst, 32'h0000_0013);
    chk("drop_still_req", imem_req, 1);
    fetch(32'h0000_0000, 32'hB000_0001, 32'h0000_0004, 0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- PC register and instruction-fetch sequencer. It sits directly upstream and downstream of mux_pc.
- Supplies curr_pc and ena to mux_pc. Latches next_pc when the current instruction retires.
- Issues one fetch at a time to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction to decode with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_WIDTH, 32, width of retired-instruction counter.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- next_pc  input  `CPU_WIDTH  next PC from mux_pc.
- curr_pc  output  `CPU_WIDTH  PC of the instruction being fetched or held.
- pc_ena  output  1  drives mux_pc ena; high only in the retire cycle.
- imem_req  output  1  fetch request.
- imem_addr  output  `CPU_WIDTH  fetch address; equals curr_pc.
- imem_gnt  input  1  request accepted.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  inst/inst_pc valid to decode.
- inst  output  32  held instruction.
- inst_pc  output  `CPU_WIDTH  PC of the held instruction.
- inst_ready  input  1  decode/execute retires the instruction this cycle.
- misalign_err  output  1  sticky; next_pc[1:0] was nonzero at retire.
- retire_cnt  output  CNT_WIDTH  retired-instruction count, wraps.

Behaviour:
- Clock and reset: clk is the single clock. rst_n is asynchronous and active-low.
- Reset values:
  - curr_pc = RESET_PC.
  - state = IDLE.
  - inst = 32'h0000_0013 (nop).
  - inst_pc = RESET_PC.
  - inst_valid, imem_req, pc_ena, misalign_err = 0.
  - retire_cnt = 0.
- FSM states: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE:
  - Occupies exactly one cycle after reset release, then goes to REQ.
  - imem_req = 0.
- REQ:
  - imem_req = 1, imem_addr = curr_pc.
  - imem_gnt = 1 -> WAIT; otherwise stay.
  - Request and address stay stable until granted.
- WAIT:
  - imem_req = 0.
  - imem_rvalid = 1 -> inst <= imem_rdata, inst_pc <= curr_pc, inst_valid <= 1, go to HOLD.
- HOLD:
  - inst_valid = 1; inst and inst_pc stay stable.
  - pc_ena = inst_ready (combinational from state and inst_ready).
  - On inst_ready with next_pc[1:0] == 0:
    - curr_pc <= next_pc.
    - inst_valid <= 0.
    - retire_cnt <= retire_cnt + 1, wrapping at 2^CNT_WIDTH.
    - go to REQ.
  - On inst_ready with next_pc[1:0] != 0:
    - curr_pc unchanged.
    - misalign_err <= 1.
    - inst_valid <= 0.
    - retire_cnt still increments.
    - go to HALT.
- HALT:
  - Terminal until reset.
  - No requests; inst_valid = 0.
- Stale responses: imem_rvalid seen in IDLE, REQ, HOLD or HALT is ignored. Only one transaction is ever outstanding.
- Latency:
  - gnt at cycle n means rvalid is legal from n+1 onward.
  - inst_valid rises the cycle after rvalid.
  - Minimum retire-to-next-request gap is 1 cycle; minimum fetch loop is 3 cycles per instruction.
- Handshake violations:
  - imem_gnt outside REQ is ignored.
  - inst_ready while inst_valid = 0 is ignored (pc_ena = 0).
- Reset mid-operation:
  - Asynchronous return to reset values from any state.
  - An in-flight memory response arriving after reset is dropped by the IDLE/REQ rules.
- Width: PC arithmetic is done in mux_pc; this block only registers PCs, with no add.

Decomposition:
- rvseed_defines.v holds:
  - `CPU_WIDTH`.
  - FSM encodings `IF_IDLE`, `IF_REQ`, `IF_WAIT`, `IF_HOLD`, `IF_HALT` (3-bit).
  - `INST_NOP` 32'h0000_0013.
- No sub-module. The PC register, instruction buffer and counter stay flat; mux_pc is instantiated by the parent core, not inside this block.

Test Plan:
- Reset release, gnt held 1, rvalid one cycle after gnt, inst_ready=1 → imem_addr 0x0 then 0x4, 0x8 with next_pc = curr_pc+4; retire_cnt increments once per instruction; one fetch every 3 cycles.
- gnt withheld 5 cycles → imem_req and imem_addr=0x4 stable all 5 cycles; no state change.
- inst_ready held 0 for 4 cycles in HOLD → inst, inst_pc stable and inst_valid=1; pc_ena=0 throughout; then a single retire.
- next_pc=0x100 (taken branch) at retire → next imem_addr=0x100 and inst_pc=0x100 on the following instruction.
- next_pc=0x102 at retire → misalign_err=1, HALT entered, imem_req stays 0; rst_n low clears the error and restarts at RESET_PC.
- rst_n asserted while in WAIT, with rvalid arriving 1 cycle after release → data dropped, inst_valid stays 0, fresh request issued at RESET_PC; also a spurious rvalid in HOLD leaves inst unchanged.
